// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction-bus req/ack, EX redirect, and the ID-facing {pc, inst, valid}.
// master = fetch stage, slave = bus/ID/EX environment.
interface if_stage_if;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        id_stall;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  modport master (
    output ibus_req, ibus_addr, id_pc, id_inst, id_valid,
    input  ibus_ack, ibus_rdata, branch_flag, branch_target, id_stall
  );

  modport slave (
    input  ibus_req, ibus_addr, id_pc, id_inst, id_valid,
    output ibus_ack, ibus_rdata, branch_flag, branch_target, id_stall
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC owner, req/ack bus master, 1-entry skid buffer towards ID, EX redirects.
// Latency: the word acked in cycle N is on id_* in N+1; ID stall parks it in the skid buffer and drops req.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic       clk,
  input logic       rst,
  if_stage_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_t;

  state_t      r_state,    w_state_nxt;
  logic [31:0] r_pc,       w_pc_nxt;
  logic [31:0] r_id_pc,    w_id_pc_nxt;
  logic [31:0] r_id_inst,  w_id_inst_nxt;
  logic        r_id_valid, w_id_valid_nxt;
  logic [31:0] r_buf_pc,   w_buf_pc_nxt;
  logic [31:0] r_buf_inst, w_buf_inst_nxt;
  logic [31:0] r_redir,    w_redir_nxt;

  logic [31:0] w_tgt;
  logic [31:0] w_pc_inc;

  assign w_tgt    = bus.branch_target & 32'hFFFF_FFFC;
  assign w_pc_inc = r_pc + 32'd4;

  // req is a pure function of state so an async reset drops it immediately
  assign bus.ibus_req  = (r_state == S_REQ) || (r_state == S_DROP);
  assign bus.ibus_addr = r_pc & 32'hFFFF_FFFC;
  assign bus.id_pc     = r_id_pc;
  assign bus.id_inst   = r_id_inst;
  assign bus.id_valid  = r_id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_id_pc    <= 32'h0;
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
      r_buf_pc   <= 32'h0;
      r_buf_inst <= 32'h0;
      r_redir    <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_id_pc    <= w_id_pc_nxt;
      r_id_inst  <= w_id_inst_nxt;
      r_id_valid <= w_id_valid_nxt;
      r_buf_pc   <= w_buf_pc_nxt;
      r_buf_inst <= w_buf_inst_nxt;
      r_redir    <= w_redir_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_id_pc_nxt    = r_id_pc;
    w_id_inst_nxt  = r_id_inst;
    w_id_valid_nxt = r_id_valid;
    w_buf_pc_nxt   = r_buf_pc;
    w_buf_inst_nxt = r_buf_inst;
    w_redir_nxt    = r_redir;

    if (bus.branch_flag) begin
      // flush outranks stall and ack; the skid entry dies by leaving HOLD
      w_id_valid_nxt = 1'b0;
      w_id_inst_nxt  = NOP_INST;
      unique case (r_state)
        S_REQ: begin
          if (bus.ibus_ack) begin
            w_pc_nxt = w_tgt;
          end else begin
            w_redir_nxt = w_tgt;
            w_state_nxt = S_DROP;
          end
        end
        S_DROP: begin
          if (bus.ibus_ack) begin
            w_pc_nxt    = w_tgt;
            w_state_nxt = S_REQ;
          end else begin
            w_redir_nxt = w_tgt;
          end
        end
        default: begin
          w_pc_nxt    = w_tgt;
          w_state_nxt = S_REQ;
        end
      endcase
    end else begin
      unique case (r_state)
        S_IDLE: w_state_nxt = S_REQ;
        S_REQ: begin
          if (bus.ibus_ack && !bus.id_stall) begin
            w_id_inst_nxt  = bus.ibus_rdata;
            w_id_pc_nxt    = r_pc;
            w_id_valid_nxt = 1'b1;
            w_pc_nxt       = w_pc_inc;
          end else if (bus.ibus_ack) begin
            w_buf_pc_nxt   = r_pc;
            w_buf_inst_nxt = bus.ibus_rdata;
            w_pc_nxt       = w_pc_inc;
            w_state_nxt    = S_HOLD;
          end else if (!bus.id_stall) begin
            w_id_valid_nxt = 1'b0;
            w_id_inst_nxt  = NOP_INST;
          end
        end
        S_HOLD: begin
          if (!bus.id_stall) begin
            w_id_pc_nxt    = r_buf_pc;
            w_id_inst_nxt  = r_buf_inst;
            w_id_valid_nxt = 1'b1;
            w_state_nxt    = S_REQ;
          end
        end
        S_DROP: begin
          if (bus.ibus_ack) begin
            w_pc_nxt    = r_redir;
            w_state_nxt = S_REQ;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table, hand sequence for wrap/async reset, random run vs transaction model.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  if_stage_if bus1();
  if_stage_if bus2();

  assign bus1.ibus_rdata = bus1.ibus_addr | 32'h1;
  assign bus2.ibus_rdata = bus2.ibus_addr | 32'h1;

  if_stage u_dut (.clk(clk), .rst(rst), .bus(bus1));
  if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (.clk(clk), .rst(rst2), .bus(bus2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ack, stall, br;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic vec_t mk(logic a, logic s, logic b, logic [31:0] t,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] ep);
    vec_t v;
    v.ack = a; v.stall = s; v.br = b; v.tgt = t;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    return v;
  endfunction

  typedef struct { logic [31:0] pc, inst; } item_t;
  item_t       q[$];
  logic [31:0] exp_pc;
  bit          stale;
  bit          prev_req, prev_ack;
  logic [31:0] prev_addr;
  int          wait_cnt;
  int          n_consumed;

  // one random cycle: check outputs, pick inputs, score consumption, advance the model
  task automatic rand_cycle(input bit quiet);
    logic        o_req, o_valid, ack, stall, br;
    logic [31:0] o_addr, o_pc, o_inst, tgt;
    item_t       it;
    o_req = bus1.ibus_req; o_addr = bus1.ibus_addr;
    o_valid = bus1.id_valid; o_pc = bus1.id_pc; o_inst = bus1.id_inst;
    if (o_req) begin
      if (prev_req && !prev_ack) chk("addr_stable", o_addr, prev_addr);
      if (!stale) chk("addr_pc", o_addr, exp_pc);
    end
    if (!o_valid) chk("bubble_nop", o_inst, NOP);

    ack = 1'b0;
    if (o_req && !quiet) begin
      if (wait_cnt == 0) begin
        ack = 1'b1;
        wait_cnt = $urandom_range(0, 3);
      end else begin
        wait_cnt--;
      end
    end
    stall = !quiet && ($urandom_range(0, 99) < 25);
    br    = !quiet && ($urandom_range(0, 99) < 6);
    tgt   = $urandom;
    bus1.ibus_ack = ack; bus1.id_stall = stall;
    bus1.branch_flag = br; bus1.branch_target = tgt;

    if (o_valid && !br && !stall) begin
      if (q.size() == 0) begin
        chk("spurious_valid", o_pc, 32'hDEAD_BEEF);
      end else begin
        it = q.pop_front();
        chk("deliver_pc", o_pc, it.pc);
        chk("deliver_inst", o_inst, it.inst);
        n_consumed++;
      end
    end

    if (br) begin
      q.delete();
      exp_pc = tgt & 32'hFFFF_FFFC;
      stale  = o_req && !ack;
    end else if (o_req && ack) begin
      if (stale) begin
        stale = 1'b0;
      end else begin
        q.push_back('{pc: exp_pc, inst: exp_pc | 32'h1});
        exp_pc = exp_pc + 32'd4;
      end
    end
    prev_req = o_req; prev_ack = ack; prev_addr = o_addr;
    @(negedge clk);
  endtask

  vec_t vt[22];

  initial begin
    vt[0]  = mk(0,0,0,32'h0,   0,32'h000,0,32'h000);
    vt[1]  = mk(1,0,0,32'h0,   1,32'h000,0,32'h000);
    vt[2]  = mk(1,0,0,32'h0,   1,32'h004,1,32'h000);
    vt[3]  = mk(1,1,0,32'h0,   1,32'h008,1,32'h004);
    vt[4]  = mk(0,1,0,32'h0,   0,32'h00C,1,32'h004);
    vt[5]  = mk(0,1,0,32'h0,   0,32'h00C,1,32'h004);
    vt[6]  = mk(0,1,0,32'h0,   0,32'h00C,1,32'h004);
    vt[7]  = mk(0,0,0,32'h0,   0,32'h00C,1,32'h004);
    vt[8]  = mk(0,0,0,32'h0,   1,32'h00C,1,32'h008);
    vt[9]  = mk(0,0,0,32'h0,   1,32'h00C,0,32'h008);
    vt[10] = mk(1,0,0,32'h0,   1,32'h00C,0,32'h008);
    vt[11] = mk(0,0,0,32'h0,   1,32'h010,1,32'h00C);
    vt[12] = mk(0,0,1,32'h100, 1,32'h010,0,32'h00C);
    vt[13] = mk(0,0,0,32'h0,   1,32'h010,0,32'h00C);
    vt[14] = mk(1,0,0,32'h0,   1,32'h010,0,32'h00C);
    vt[15] = mk(1,0,0,32'h0,   1,32'h100,0,32'h00C);
    vt[16] = mk(1,0,1,32'h203, 1,32'h104,1,32'h100);
    vt[17] = mk(1,0,0,32'h0,   1,32'h200,0,32'h100);
    vt[18] = mk(1,1,0,32'h0,   1,32'h204,1,32'h200);
    vt[19] = mk(0,1,1,32'h300, 0,32'h208,1,32'h200);
    vt[20] = mk(0,0,0,32'h0,   1,32'h300,0,32'h200);
    vt[21] = mk(0,0,0,32'h0,   1,32'h300,0,32'h200);

    bus1.ibus_ack = 0; bus1.id_stall = 0; bus1.branch_flag = 0; bus1.branch_target = 0;
    bus2.ibus_ack = 0; bus2.id_stall = 0; bus2.branch_flag = 0; bus2.branch_target = 0;

    repeat (2) @(negedge clk);
    chk("rst_req",   {31'b0, bus1.ibus_req}, 32'h0);
    chk("rst_valid", {31'b0, bus1.id_valid}, 32'h0);
    chk("rst_inst",  bus1.id_inst, NOP);
    chk("rst_pc",    bus1.id_pc, 32'h0);
    chk("rst_addr",  bus1.ibus_addr, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      chk($sformatf("v%0d_req", i),   {31'b0, bus1.ibus_req}, {31'b0, vt[i].exp_req});
      chk($sformatf("v%0d_addr", i),  bus1.ibus_addr, vt[i].exp_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, bus1.id_valid}, {31'b0, vt[i].exp_valid});
      chk($sformatf("v%0d_pc", i),    bus1.id_pc, vt[i].exp_pc);
      chk($sformatf("v%0d_inst", i),  bus1.id_inst, vt[i].exp_valid ? (vt[i].exp_pc | 32'h1) : NOP);
      bus1.ibus_ack = vt[i].ack; bus1.id_stall = vt[i].stall;
      bus1.branch_flag = vt[i].br; bus1.branch_target = vt[i].tgt;
      @(negedge clk);
    end

    // PC wrap at the top of the address space, then async reset while a request is up
    rst2 = 1'b0; bus2.ibus_ack = 1'b1;
    chk("hi_idle_req", {31'b0, bus2.ibus_req}, 32'h0);
    @(negedge clk);
    chk("hi_addr0", bus2.ibus_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("hi_addr1", bus2.ibus_addr, 32'hFFFF_FFFC);
    chk("hi_pc0",   bus2.id_pc, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("hi_addr2", bus2.ibus_addr, 32'h0000_0000);
    chk("hi_pc1",   bus2.id_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("hi_pc2",   bus2.id_pc, 32'h0000_0000);
    chk("hi_req_pre", {31'b0, bus2.ibus_req}, 32'h1);
    @(posedge clk);
    #2 rst2 = 1'b1;
    #1;
    chk("arst_req",   {31'b0, bus2.ibus_req}, 32'h0);
    chk("arst_valid", {31'b0, bus2.id_valid}, 32'h0);
    chk("arst_inst",  bus2.id_inst, NOP);
    chk("arst_addr",  bus2.ibus_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    rst2 = 1'b0;
    chk("arst_idle", {31'b0, bus2.ibus_req}, 32'h0);
    @(negedge clk);
    chk("arst_refetch_req",  {31'b0, bus2.ibus_req}, 32'h1);
    chk("arst_refetch_addr", bus2.ibus_addr, 32'hFFFF_FFF8);
    bus2.ibus_ack = 1'b0;

    rst = 1'b1;
    bus1.ibus_ack = 0; bus1.id_stall = 0; bus1.branch_flag = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete(); exp_pc = 32'h0; stale = 0;
    prev_req = 0; prev_ack = 0; prev_addr = 0; wait_cnt = 0; n_consumed = 0;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b0);
    for (int c = 0; c < 6; c++) rand_cycle(1'b1);
    chk("drained", q.size(), 32'h0);
    n_tests++;
    if (n_consumed < 200) begin
      n_fail++;
      $display("FAIL throughput: got %0d deliveries, expected at least 200", n_consumed);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
